// File: rtl/flex_counter_bank.sv
// Bank of independent flexible counters with WRAP, SATURATE and ONESHOT
// modes, per-channel clear/load/enable/direction and registered status.
module flex_counter_bank #(
  parameter int NUM_CNT_BITS = 8,
  parameter int NUM_CH       = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              count_up,
  input  logic [2*NUM_CH-1:0]            mode,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              rollover_pulse,
  output logic [NUM_CH-1:0]              done,
  output logic                           any_rollover
);

  localparam logic [1:0] M_SAT     = 2'b01;
  localparam logic [1:0] M_ONESHOT = 2'b10;
  localparam logic [NUM_CNT_BITS-1:0] INC = NUM_CNT_BITS'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [NUM_CNT_BITS-1:0] cnt_q;
    logic [NUM_CNT_BITS-1:0] cnt_d;
    logic [NUM_CNT_BITS-1:0] rv;
    logic [NUM_CNT_BITS-1:0] lv;
    logic [NUM_CNT_BITS-1:0] term;
    logic [1:0]              md;
    logic                    flag_q;
    logic                    pulse_q;
    logic                    done_q;
    logic                    flag_d;
    logic                    pulse_d;
    logic                    done_d;
    logic                    free_run;
    logic                    at_term;

    assign rv = rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
    assign lv = load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
    assign md = mode[2*i +: 2];

    assign term     = count_up[i] ? rv : '0;
    // Up-counting with a zero terminal is a plain modulo counter.
    assign free_run = count_up[i] && (rv == '0);
    assign at_term  = (cnt_q == term);

    always_comb begin
      cnt_d   = cnt_q;
      done_d  = done_q;
      pulse_d = 1'b0;
      if (clear[i]) begin
        cnt_d  = '0;
        done_d = 1'b0;
      end else if (load[i]) begin
        cnt_d  = lv;
        done_d = 1'b0;
      end else if (count_enable[i] && !done_q) begin
        if (free_run || !at_term) begin
          cnt_d = count_up[i] ? cnt_q + INC : cnt_q - INC;
        end else if (md == M_SAT) begin
          cnt_d = cnt_q;
        end else if (md == M_ONESHOT) begin
          done_d = 1'b1;
        end else begin
          cnt_d   = count_up[i] ? INC : rv - INC;
          pulse_d = 1'b1;
        end
      end
      flag_d = (cnt_d == term);
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        cnt_q   <= '0;
        flag_q  <= 1'b0;
        pulse_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        flag_q  <= flag_d;
        pulse_q <= pulse_d;
        done_q  <= done_d;
      end
    end

    assign count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS] = cnt_q;
    assign rollover_flag[i]  = flag_q;
    assign rollover_pulse[i] = pulse_q;
    assign done[i]           = done_q;
  end

  assign any_rollover = |rollover_flag;

endmodule

// File: tb/tb_flex_counter_bank.sv
// Directed and randomized checks of flex_counter_bank (4-bit, 2 channels)
// against an arithmetic reference model.
module tb_flex_counter_bank;

  localparam int N  = 4;
  localparam int CH = 2;
  localparam int M  = 1 << N;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [CH-1:0]   clear;
  logic [CH-1:0]   load;
  logic [CH*N-1:0] load_val;
  logic [CH-1:0]   count_enable;
  logic [CH-1:0]   count_up;
  logic [2*CH-1:0] mode;
  logic [CH*N-1:0] rollover_val;
  logic [CH*N-1:0] count_out;
  logic [CH-1:0]   rollover_flag;
  logic [CH-1:0]   rollover_pulse;
  logic [CH-1:0]   done;
  logic            any_rollover;

  int vectors = 0;
  int errors  = 0;

  int m_cnt[CH];
  int m_flag[CH];
  int m_pulse[CH];
  int m_done[CH];
  int n_cnt[CH];
  int n_flag[CH];
  int n_pulse[CH];
  int n_done[CH];

  int seq_wrap[7] = '{1, 2, 3, 4, 5, 1, 2};
  int seq_sat[5]  = '{1, 2, 3, 3, 3};
  int seq_one[5]  = '{3, 2, 1, 0, 0};

  flex_counter_bank #(.NUM_CNT_BITS(N), .NUM_CH(CH)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .load          (load),
    .load_val      (load_val),
    .count_enable  (count_enable),
    .count_up      (count_up),
    .mode          (mode),
    .rollover_val  (rollover_val),
    .count_out     (count_out),
    .rollover_flag (rollover_flag),
    .rollover_pulse(rollover_pulse),
    .done          (done),
    .any_rollover  (any_rollover)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_flag[i] = 0; m_pulse[i] = 0; m_done[i] = 0;
    end
  endtask

  // Next state straight from the channel rules, in integer arithmetic.
  task automatic model_next();
    for (int i = 0; i < CH; i++) begin
      int r;
      int t;
      int c;
      int md;
      bit up;
      r  = int'(rollover_val[i*N +: N]);
      md = int'(mode[2*i +: 2]);
      up = count_up[i];
      t  = up ? r : 0;
      c  = m_cnt[i];
      n_done[i]  = m_done[i];
      n_pulse[i] = 0;
      if (clear[i]) begin
        c = 0; n_done[i] = 0;
      end else if (load[i]) begin
        c = int'(load_val[i*N +: N]); n_done[i] = 0;
      end else if (count_enable[i] && m_done[i] == 0) begin
        if ((up && r == 0) || c != t) c = up ? (c + 1) % M : (c + M - 1) % M;
        else if (md == 1) c = c;
        else if (md == 2) n_done[i] = 1;
        else begin
          c = up ? 1 : (r + M - 1) % M;
          n_pulse[i] = 1;
        end
      end
      n_cnt[i]  = c;
      n_flag[i] = (c == t) ? 1 : 0;
    end
  endtask

  task automatic check_all();
    int any;
    any = 0;
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("count%0d", i), 32'(count_out[i*N +: N]), m_cnt[i]);
      chk($sformatf("flag%0d", i), 32'(rollover_flag[i]), m_flag[i]);
      chk($sformatf("pulse%0d", i), 32'(rollover_pulse[i]), m_pulse[i]);
      chk($sformatf("done%0d", i), 32'(done[i]), m_done[i]);
      any = any | m_flag[i];
    end
    chk("any_rollover", 32'(any_rollover), any);
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = n_cnt[i]; m_flag[i] = n_flag[i];
      m_pulse[i] = n_pulse[i]; m_done[i] = n_done[i];
    end
    #1;
    check_all();
  endtask

  initial begin
    n_rst = 1'b0;
    clear = '0; load = '0; load_val = '0; count_enable = '0;
    count_up = '1; mode = '0; rollover_val = '0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    n_rst = 1'b1;

    // ch0 up WRAP, R=5
    clear = 2'b11; rollover_val = {4'd3, 4'd5};
    tick();
    clear = 2'b00; count_enable = 2'b01;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("wrap_cnt", 32'(count_out[3:0]), seq_wrap[k]);
      chk("wrap_flag", 32'(rollover_flag[0]), (seq_wrap[k] == 5) ? 1 : 0);
      chk("wrap_pulse", 32'(rollover_pulse[0]), (k == 5) ? 1 : 0);
    end

    // ch0 up SATURATE, R=3
    clear = 2'b01; mode = 4'b0001; rollover_val = {4'd3, 4'd3};
    tick();
    clear = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_cnt", 32'(count_out[3:0]), seq_sat[k]);
      chk("sat_flag", 32'(rollover_flag[0]), (k >= 2) ? 1 : 0);
      chk("sat_pulse", 32'(rollover_pulse[0]), 0);
    end

    // ch1 down ONESHOT from a load of 4
    count_enable = 2'b00; count_up = 2'b01; mode = 4'b1001;
    load = 2'b10; load_val = {4'd4, 4'd0};
    tick();
    chk("one_load", 32'(count_out[7:4]), 4);
    load = 2'b00; count_enable = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("one_cnt", 32'(count_out[7:4]), seq_one[k]);
      chk("one_done", 32'(done[1]), (k == 4) ? 1 : 0);
    end
    tick();
    chk("one_hold", 32'(count_out[7:4]), 0);
    chk("one_hold_done", 32'(done[1]), 1);
    load = 2'b10; load_val = {4'd7, 4'd0};
    tick();
    chk("one_reload", 32'(count_out[7:4]), 7);
    chk("one_reload_done", 32'(done[1]), 0);

    // clear and load together on ch0; ch1 undisturbed
    load = 2'b01; load_val = {4'd2, 4'd9}; count_enable = 2'b00;
    tick();
    chk("cl_pre", 32'(count_out[3:0]), 9);
    clear = 2'b01; load = 2'b01; load_val = {4'd2, 4'd6};
    tick();
    chk("cl_cnt0", 32'(count_out[3:0]), 0);
    chk("cl_done0", 32'(done[0]), 0);
    chk("cl_cnt1", 32'(count_out[7:4]), 7);

    // asynchronous reset mid-count
    clear = 2'b00; load = 2'b00; mode = 4'b0000;
    count_up = 2'b11; rollover_val = {4'd9, 4'd5}; count_enable = 2'b11;
    tick(); tick(); tick();
    #1 n_rst = 1'b0;
    #1;
    model_reset();
    chk("rst_cnt", 32'(count_out), 0);
    chk("rst_flag", 32'(rollover_flag), 0);
    chk("rst_pulse", 32'(rollover_pulse), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_any", 32'(any_rollover), 0);
    #1 n_rst = 1'b1;
    tick();
    chk("rst_resume", 32'(count_out[3:0]), 1);

    // ch0 up WRAP R=0 free-runs; ch1 up WRAP R=3
    clear = 2'b11; rollover_val = {4'd3, 4'd0};
    tick();
    clear = 2'b00; count_enable = 2'b11;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("free_cnt", 32'(count_out[3:0]), (k + 1) % 16);
      chk("free_flag", 32'(rollover_flag[0]), (k == 15) ? 1 : 0);
    end

    // randomized traffic, including count above R and live R/mode changes
    for (int k = 0; k < 400; k++) begin
      clear        = 2'($urandom_range(0, 15) == 0) | (2'($urandom_range(0, 15) == 0) << 1);
      load         = 2'($urandom_range(0, 9) == 0) | (2'($urandom_range(0, 9) == 0) << 1);
      load_val     = 8'($urandom);
      count_enable = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) count_up = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) mode = 4'($urandom);
      if ($urandom_range(0, 9) == 0)
        rollover_val = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/flex_counter_bank.md
FLEX_COUNTER_BANK -- requirements
Module: flex_counter_bank

Interface
REQ-001 The block SHALL have parameter NUM_CNT_BITS, default 8, giving the counter width per channel.
REQ-002 The block SHALL have parameter NUM_CH, default 4, giving the number of independent counter channels.
REQ-003 Port clk SHALL be an input, 1 bit wide: the clock; all state updates on its rising edge.
REQ-004 Port n_rst SHALL be an input, 1 bit wide: reset, asynchronous, active-low.
REQ-005 Port clear SHALL be an input, NUM_CH bits wide: per-channel synchronous clear.
REQ-006 Port load SHALL be an input, NUM_CH bits wide: per-channel synchronous load.
REQ-007 Port load_val SHALL be an input, NUM_CH*NUM_CNT_BITS bits wide: per-channel load value; channel i occupies bits [i*NUM_CNT_BITS +: NUM_CNT_BITS].
REQ-008 Port count_enable SHALL be an input, NUM_CH bits wide: per-channel count enable.
REQ-009 Port count_up SHALL be an input, NUM_CH bits wide: per-channel direction, 1 = up, 0 = down.
REQ-010 Port mode SHALL be an input, 2*NUM_CH bits wide: per-channel mode; 00 = WRAP, 01 = SATURATE, 10 = ONESHOT, 11 = reserved (behaves as WRAP).
REQ-011 Port rollover_val SHALL be an input, NUM_CH*NUM_CNT_BITS bits wide: per-channel terminal value, packed the same way as load_val.
REQ-012 Port count_out SHALL be an output, NUM_CH*NUM_CNT_BITS bits wide: registered per-channel count, packed the same way as load_val.
REQ-013 Port rollover_flag SHALL be an output, NUM_CH bits wide: registered; high while the channel count equals its terminal value.
REQ-014 Port rollover_pulse SHALL be an output, NUM_CH bits wide: registered; a one-cycle pulse per wrap event.
REQ-015 Port done SHALL be an output, NUM_CH bits wide: registered; high when a ONESHOT channel has halted.
REQ-016 Port any_rollover SHALL be an output, 1 bit wide: combinational OR of rollover_flag.

Function
REQ-017 Each channel SHALL operate independently, with no interaction between channels.
REQ-018 Per-channel priority SHALL be clear > load > count_enable > hold.
REQ-019 On clear, the channel SHALL set count to 0, set done to 0 and set rollover_pulse to 0; rollover_flag SHALL then follow REQ-024.
REQ-020 On load, the channel SHALL set count to load_val and set done to 0.
REQ-021 The terminal value SHALL be rollover_val when counting up and 0 when counting down.
REQ-022 On an enabled count from a non-terminal value, the channel SHALL step by +1 (up) or -1 (down), modulo 2^NUM_CNT_BITS.
REQ-023 On an enabled count from the terminal value, the next count SHALL depend on the mode:
  - WRAP, up: next count is 1.
  - WRAP, down: next count is rollover_val-1.
  - SATURATE: count holds.
  - ONESHOT: count holds and done is set.
REQ-024 rollover_flag SHALL be registered from the next count and SHALL equal (next count == terminal value for the current direction).
REQ-025 rollover_pulse SHALL be high for exactly the one cycle after a WRAP-mode terminal step; it is never asserted in SATURATE or ONESHOT mode.
REQ-026 While done=1, count_enable SHALL be ignored; only clear or load releases the channel.
REQ-027 If rollover_val=0 in up mode, the channel SHALL free-run modulo 2^NUM_CNT_BITS, with rollover_flag high only at count 0 and no wrap to 1.
REQ-028 In up mode with count > rollover_val (after a load or a rollover_val change), the channel SHALL count up to all-ones, wrap to 0, and flag only on equality.
REQ-029 Changes to direction, mode or rollover_val SHALL take effect on the next enabled edge; no state is reset by such a change.
REQ-030 The arithmetic SHALL be NUM_CNT_BITS wide unsigned, with no carry or borrow outputs.

Reset
REQ-031 While n_rst=0, without waiting for a clock edge, the block SHALL hold every count_out at 0 and rollover_flag, rollover_pulse, done and any_rollover all at 0.
REQ-032 The first rising clk edge after n_rst deasserts SHALL apply the normal per-channel rules.

Verification
REQ-033 The bench SHALL cover (N=4, CH=2): ch0 up WRAP, R=5, enable held -> count_out 1,2,3,4,5,1,2; rollover_flag high only at 5; rollover_pulse high only the cycle count=1 follows 5.
REQ-034 The bench SHALL cover: ch0 up SATURATE, R=3 -> 1,2,3,3,3; rollover_flag stays 1; rollover_pulse never asserts.
REQ-035 The bench SHALL cover: ch1 down ONESHOT, load 4 -> 4,3,2,1,0,0; done=1 with count 0 held; then a load of 7 -> count 7, done=0.
REQ-036 The bench SHALL cover: clear and load asserted in the same cycle on ch0 at count 9 -> count 0, done 0; the same cycle on ch1 is unaffected.
REQ-037 The bench SHALL cover: n_rst pulsed low mid-count with no clock edge -> all outputs 0 immediately; counting resumes from 0 (up: 1) after release.
REQ-038 The bench SHALL cover: ch0 up WRAP, R=0 -> 0..15 then 0; rollover_flag only at 0; any_rollover tracks the OR of both channels.
